// File: rtl/foo_pkg.sv
// Shared types and helpers for the foo link collector.
package foo_pkg;

  function automatic int unsigned foo_lane_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned FOO_N  = 5;
  localparam int unsigned FOO_LW = foo_lane_w(FOO_N);

  typedef struct packed {
    logic [FOO_LW-1:0] lane;
    logic              level;
  } foo_evt_t;

endpackage

// File: rtl/foo_intf.sv
// Single-wire foo link; sources drive a, sinks observe it.
interface foo_intf;
  logic a;

  modport source (output a);
  modport sink   (input a);
endinterface

// File: rtl/foo_evt_fifo.sv
// Event FIFO with synchronous push/pop, occupancy count and async reset.
module foo_evt_fifo
  import foo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         EVT_T = foo_evt_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  EVT_T                   data_i,
  input  logic                   pop_i,
  output EVT_T                   head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  EVT_T             mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  // A push into a full FIFO is legal only when the head leaves at the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign head_o = empty_o ? EVT_T'('0) : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/foo_sink_collector.sv
// Per-lane level-change detector with round-robin arbitration into an event FIFO.
module foo_sink_collector
  import foo_pkg::*;
#(
  parameter int unsigned N     = 5,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = foo_lane_w(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  foo_intf.sink                  foos [N-1:0],
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [LW-1:0]          evt_lane,
  output logic                   evt_level,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic                   coalesced
);

  typedef struct packed {
    logic [LW-1:0] lane;
    logic          level;
  } evt_t;

  logic [N-1:0]  a_vec;
  logic [N-1:0]  prev_q, prev_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [LW-1:0] rr_q, rr_d;
  logic          coal_q, coal_d;

  logic [N-1:0]  change;
  logic [N-1:0]  clr;
  logic [LW-1:0] sel;
  logic          found;
  logic          push, pop;
  logic          fifo_full, fifo_empty;
  evt_t          push_evt, head_evt;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign a_vec[i] = foos[i].a;
  end

  assign change = a_vec ^ prev_q;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && pending_q[LW'((32'(rr_q) + k) % N)]) begin
        found = 1'b1;
        sel   = LW'((32'(rr_q) + k) % N);
      end
    end
  end

  assign pop  = evt_valid && evt_ready;
  assign push = found && (!fifo_full || pop);

  assign push_evt.lane  = sel;
  assign push_evt.level = prev_q[sel];

  // A change landing on the lane being cleared re-arms it without counting as coalescing.
  always_comb begin
    clr = '0;
    if (push) clr[sel] = 1'b1;
    prev_d    = a_vec;
    pending_d = (pending_q & ~clr) | change;
    coal_d    = coal_q | (|(change & pending_q & ~clr));
    rr_d      = rr_q;
    if (push) rr_d = (sel == LW'(N - 1)) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '0;
      pending_q <= '0;
      rr_q      <= '0;
      coal_q    <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      coal_q    <= coal_d;
    end
  end

  foo_evt_fifo #(
    .DEPTH (DEPTH),
    .EVT_T (evt_t)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (push_evt),
    .pop_i   (pop),
    .head_o  (head_evt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (evt_count)
  );

  assign evt_valid = !fifo_empty;
  assign evt_lane  = head_evt.lane;
  assign evt_level = head_evt.level;
  assign coalesced = coal_q;

endmodule

// File: tb/tb_foo_sink_collector.sv
// Bench for foo_sink_collector: hand-derived vector table plus a cycle model scoreboard.
module tb_foo_sink_collector;

  localparam int N     = 5;
  localparam int DEPTH = 4;
  localparam int NROWS = 21;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] lanes = '0;
  logic       ready = 1'b0;

  logic       evt_valid;
  logic [2:0] evt_lane;
  logic       evt_level;
  logic [2:0] evt_count;
  logic       coalesced;

  int checks = 0;
  int errors = 0;

  foo_intf foos [N-1:0] ();

  for (genvar i = 0; i < N; i++) begin : g_drv
    assign foos[i].a = lanes[i];
  end

  foo_sink_collector #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .foos      (foos),
    .evt_valid (evt_valid),
    .evt_ready (ready),
    .evt_lane  (evt_lane),
    .evt_level (evt_level),
    .evt_count (evt_count),
    .coalesced (coalesced)
  );

  always #5 clk = ~clk;

  // Reference model; m_q doubles as the scoreboard of expected events.
  typedef struct {
    int   lane;
    logic lvl;
  } ev_t;

  ev_t        m_q[$];
  logic [4:0] m_prev;
  logic [4:0] m_pend;
  int         m_rr;
  logic       m_coal;

  function automatic void m_reset();
    m_q.delete();
    m_prev = '0;
    m_pend = '0;
    m_rr   = 0;
    m_coal = 1'b0;
  endfunction

  function automatic void m_edge();
    bit pop;
    bit acc;
    int sel;
    pop = (m_q.size() != 0) && ready;
    acc = (m_q.size() < DEPTH) || pop;
    sel = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (sel < 0 && m_pend[idx]) sel = idx;
    end
    if (pop) m_q.delete(0);
    if (sel >= 0 && acc) begin
      m_q.push_back('{sel, m_prev[sel]});
      m_pend[sel] = 1'b0;
      m_rr = (sel + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (lanes[i] != m_prev[i]) begin
        if (m_pend[i]) m_coal = 1'b1;
        m_pend[i] = 1'b1;
        m_prev[i] = lanes[i];
      end
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("sb_count", int'(evt_count), m_q.size());
    chk("sb_valid", int'(evt_valid), int'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("sb_lane",  int'(evt_lane),  m_q[0].lane);
      chk("sb_level", int'(evt_level), int'(m_q[0].lvl));
    end
    chk("sb_coalesced", int'(coalesced), int'(m_coal));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) m_reset();
    else     m_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       rst_before;
    logic [4:0] lanes;
    logic       ready;
    int         cnt;
    logic       vld;
    int         lane;
    logic       lvl;
    logic       coal;
  } row_t;

  row_t tbl [NROWS];
  int   dut_last [N];
  int   dut_cnt  [N];

  initial begin
    tbl = '{
      // single lane: visible two edges after the change
      '{1'b1, 5'b00100, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0},
      '{1'b0, 5'b00100, 1'b1, 1, 1'b1, 2, 1'b1, 1'b0},
      '{1'b0, 5'b00100, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0},
      // all lanes together, round-robin from 0
      '{1'b1, 5'b11111, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0},
      '{1'b0, 5'b11111, 1'b1, 1, 1'b1, 0, 1'b1, 1'b0},
      '{1'b0, 5'b11111, 1'b1, 1, 1'b1, 1, 1'b1, 1'b0},
      '{1'b0, 5'b11111, 1'b1, 1, 1'b1, 2, 1'b1, 1'b0},
      '{1'b0, 5'b11111, 1'b1, 1, 1'b1, 3, 1'b1, 1'b0},
      '{1'b0, 5'b11111, 1'b1, 1, 1'b1, 4, 1'b1, 1'b0},
      '{1'b0, 5'b11111, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0},
      // backpressure, coalescing on lane 4, full FIFO with simultaneous pop
      '{1'b1, 5'b11111, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0},
      '{1'b0, 5'b11111, 1'b0, 1, 1'b1, 0, 1'b1, 1'b0},
      '{1'b0, 5'b11111, 1'b0, 2, 1'b1, 0, 1'b1, 1'b0},
      '{1'b0, 5'b11111, 1'b0, 3, 1'b1, 0, 1'b1, 1'b0},
      '{1'b0, 5'b11111, 1'b0, 4, 1'b1, 0, 1'b1, 1'b0},
      '{1'b0, 5'b01111, 1'b0, 4, 1'b1, 0, 1'b1, 1'b1},
      '{1'b0, 5'b01111, 1'b1, 4, 1'b1, 1, 1'b1, 1'b1},
      '{1'b0, 5'b01111, 1'b1, 3, 1'b1, 2, 1'b1, 1'b1},
      '{1'b0, 5'b01111, 1'b1, 2, 1'b1, 3, 1'b1, 1'b1},
      '{1'b0, 5'b01111, 1'b1, 1, 1'b1, 4, 1'b0, 1'b1},
      '{1'b0, 5'b01111, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1}
    };

    m_reset();
    #1;
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_count", int'(evt_count), 0);
    chk("rst_lane",  int'(evt_lane),  0);
    chk("rst_level", int'(evt_level), 0);
    chk("rst_coal",  int'(coalesced), 0);
    do_reset();

    for (int r = 0; r < NROWS; r++) begin
      if (tbl[r].rst_before) do_reset();
      lanes = tbl[r].lanes;
      ready = tbl[r].ready;
      step();
      chk($sformatf("row%0d_count", r), int'(evt_count), tbl[r].cnt);
      chk($sformatf("row%0d_valid", r), int'(evt_valid), int'(tbl[r].vld));
      if (tbl[r].vld) begin
        chk($sformatf("row%0d_lane", r),  int'(evt_lane),  tbl[r].lane);
        chk($sformatf("row%0d_level", r), int'(evt_level), int'(tbl[r].lvl));
      end
      chk($sformatf("row%0d_coal", r), int'(coalesced), int'(tbl[r].coal));
    end

    // lane already high when reset releases
    rst = 1'b1;
    lanes = 5'b00001;
    ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    step();
    chk("first_valid", int'(evt_valid), 1);
    chk("first_lane",  int'(evt_lane),  0);
    chk("first_level", int'(evt_level), 1);

    // reset with 3 queued and 2 pending
    do_reset();
    lanes = 5'b11111;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_count_before", int'(evt_count), 3);
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk("mid_valid", int'(evt_valid), 0);
    chk("mid_count", int'(evt_count), 0);
    chk("mid_lane",  int'(evt_lane),  0);
    chk("mid_level", int'(evt_level), 0);
    chk("mid_coal",  int'(coalesced), 0);
    lanes = '0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("mid_after_valid", int'(evt_valid), 0);

    // free-running counter on the lanes
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      dut_last[i] = 0;
      dut_cnt[i]  = 0;
    end
    for (int c = 0; c < 32 + 16; c++) begin
      if (c < 32) lanes = 5'(c);
      step();
      if (evt_valid) begin
        dut_last[evt_lane] = int'(evt_level);
        dut_cnt[evt_lane]++;
      end
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("sweep_last_lane%0d", i), dut_last[i], int'(lanes[i]));
      chk($sformatf("sweep_seen_lane%0d", i), int'(dut_cnt[i] > 0), 1);
    end
    chk("sweep_drained", int'(evt_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
